// File: rtl/seg7_mux_counter.sv
// seg7_mux_counter: multi-digit BCD/hex counter with prescaled stepping and a multiplexed seven-segment display
module seg7_mux_counter #(
  parameter int DIGITS = 4,
  parameter int TICK_DIV = 10000000,
  parameter int REFRESH_DIV = 1000,
  parameter int HEX_MODE = 0,
  parameter int BLANK_LZ = 0
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_data,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic                  wrap,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_sel
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] P_MAX = PW'(TICK_DIV - 1);
  localparam logic [RW-1:0] R_MAX = RW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] I_MAX = IW'(DIGITS - 1);
  localparam logic [3:0] D_MAX = HEX_MODE != 0 ? 4'hF : 4'h9;

  logic [PW-1:0] pre;
  logic [RW-1:0] rcnt;
  logic [IW-1:0] idx;
  logic [4*DIGITS-1:0] stepped, loaded;
  logic [3:0] d, cur;
  logic carry, roll, step_ok, blank;
  logic [6:0] seg_nx;

  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'h0: dec = 7'h3F;
      4'h1: dec = 7'h06;
      4'h2: dec = 7'h5B;
      4'h3: dec = 7'h4F;
      4'h4: dec = 7'h66;
      4'h5: dec = 7'h6D;
      4'h6: dec = 7'h7D;
      4'h7: dec = 7'h07;
      4'h8: dec = 7'h7F;
      4'h9: dec = 7'h6F;
      4'hA: dec = 7'h77;
      4'hB: dec = 7'h7C;
      4'hC: dec = 7'h39;
      4'hD: dec = 7'h5E;
      4'hE: dec = 7'h79;
      default: dec = 7'h71;
    endcase
  endfunction

  // Ripple carry/borrow: carry stays high only while every lower digit was at its wrap value.
  always_comb begin
    stepped = count;
    loaded = load_data;
    carry = 1'b1;
    d = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      d = count[4*i +: 4];
      if (carry) stepped[4*i +: 4] = dir ? (d == 4'h0 ? D_MAX : d - 4'd1) : (d == D_MAX ? 4'h0 : d + 4'd1);
      carry = carry && (dir ? d == 4'h0 : d == D_MAX);
      loaded[4*i +: 4] = (HEX_MODE == 0 && load_data[4*i +: 4] > 4'h9) ? 4'h9 : load_data[4*i +: 4];
    end
  end

  assign roll = en && pre == P_MAX;
  assign step_ok = roll && !clear && !load;
  assign cur = count[{idx, 2'b00} +: 4];
  assign blank = BLANK_LZ != 0 && idx != '0 && (count >> {idx, 2'b00}) == '0;
  assign seg_nx = blank ? 7'h00 : dec(cur);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      pre <= '0;
      rcnt <= '0;
      idx <= '0;
      tick <= 1'b0;
      wrap <= 1'b0;
      dp <= 1'b0;
      digit_sel <= DIGITS'(1);
      segments <= 7'h3F;
    end else begin
      rcnt <= rcnt == R_MAX ? '0 : rcnt + 1'b1;
      if (rcnt == R_MAX) idx <= idx == I_MAX ? '0 : idx + 1'b1;
      digit_sel <= DIGITS'(1) << idx;
      segments <= seg_nx;
      dp <= idx == '0 && !en;
      tick <= step_ok;
      wrap <= step_ok && carry;
      if (clear) begin
        count <= '0;
        pre <= '0;
      end else if (load) begin
        count <= loaded;
        pre <= '0;
      end else if (en) begin
        pre <= roll ? '0 : pre + 1'b1;
        if (roll) count <= stepped;
      end
    end
  end
endmodule

// File: tb/tb_seg7_mux_counter.sv
// tb_seg7_mux_counter: three configurations (plain BCD, BCD with blanking, hex) against an arithmetic model plus literal checks
module tb_seg7_mux_counter;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, dir = 1'b0, clear = 1'b0, load = 1'b0;
  logic [15:0] load_data = '0;
  logic [2:0][15:0] cnt;
  logic [2:0][6:0] seg;
  logic [2:0][3:0] sel;
  logic [2:0] tick, wrap, dpo;
  int total = 0, bad = 0;
  bit chk_on = 1'b0;
  int m_val [3];
  int m_pre, m_idx, m_rcnt;
  logic e_tick, e_dp;
  logic [3:0] e_sel;
  logic [2:0] e_wrap;
  logic [6:0] e_seg [3];
  logic m_roll;
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [3:0] x_sel [8] = '{4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1};
  logic [6:0] x_seg [8] = '{7'h66, 7'h4F, 7'h4F, 7'h5B, 7'h5B, 7'h06, 7'h06, 7'h66};
  logic [6:0] x_blk [8] = '{7'h07, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h07};
  logic x_dp [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  for (genvar g = 0; g < 3; g++) begin : dut
    seg7_mux_counter #(.DIGITS(4), .TICK_DIV(4), .REFRESH_DIV(2),
      .HEX_MODE(g == 2 ? 1 : 0), .BLANK_LZ(g == 1 ? 1 : 0)) u (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .clear(clear), .load(load),
      .load_data(load_data), .count(cnt[g]), .tick(tick[g]), .wrap(wrap[g]),
      .segments(seg[g]), .dp(dpo[g]), .digit_sel(sel[g]));
  end

  always #5 clk = ~clk;

  function automatic int base(int k);
    return k == 2 ? 16 : 10;
  endfunction

  function automatic int pw(int b, int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  function automatic int clampv(logic [15:0] ld, int k);
    int r = 0;
    for (int i = 0; i < 4; i++) begin
      int n = int'(ld[4*i +: 4]);
      r = r + (n > base(k) - 1 ? base(k) - 1 : n) * pw(base(k), i);
    end
    return r;
  endfunction

  function automatic logic [15:0] bits(int v, int k);
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((v / pw(base(k), i)) % base(k));
    return r;
  endfunction

  function automatic logic [6:0] segfor(int k, int v, int i);
    int hi = v / pw(base(k), i);
    if (k == 1 && i > 0 && hi == 0) return 7'h00;
    return seg_tab[hi % base(k)];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  assign m_roll = en && m_pre == 3;

  always @(posedge clk) begin
    if (rst) begin
      chk_on <= 1'b1;
      m_pre <= 0; m_idx <= 0; m_rcnt <= 0;
      e_tick <= 1'b0; e_dp <= 1'b0; e_sel <= 4'h1; e_wrap <= '0;
      for (int k = 0; k < 3; k++) begin
        m_val[k] <= 0;
        e_seg[k] <= 7'h3F;
      end
    end else begin
      m_rcnt <= (m_rcnt + 1) % 2;
      if (m_rcnt == 1) m_idx <= (m_idx + 1) % 4;
      e_sel <= 4'(1 << m_idx);
      e_dp <= m_idx == 0 && !en;
      e_tick <= m_roll && !clear && !load;
      if (clear || load) m_pre <= 0;
      else if (en) m_pre <= (m_pre + 1) % 4;
      for (int k = 0; k < 3; k++) begin
        e_seg[k] <= segfor(k, m_val[k], m_idx);
        e_wrap[k] <= m_roll && !clear && !load && (dir ? m_val[k] == 0 : m_val[k] == pw(base(k), 4) - 1);
        if (clear) m_val[k] <= 0;
        else if (load) m_val[k] <= clampv(load_data, k);
        else if (m_roll) m_val[k] <= dir ? (m_val[k] + pw(base(k), 4) - 1) % pw(base(k), 4) : (m_val[k] + 1) % pw(base(k), 4);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("model_count%0d", k), 32'(cnt[k]), 32'(bits(m_val[k], k)));
        chk($sformatf("model_tick%0d", k), 32'(tick[k]), 32'(e_tick));
        chk($sformatf("model_wrap%0d", k), 32'(wrap[k]), 32'(e_wrap[k]));
        chk($sformatf("model_seg%0d", k), 32'(seg[k]), 32'(e_seg[k]));
        chk($sformatf("model_dp%0d", k), 32'(dpo[k]), 32'(e_dp));
        chk($sformatf("model_sel%0d", k), 32'(sel[k]), 32'(e_sel));
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  task automatic do_load(logic [15:0] v);
    load = 1'b1;
    load_data = v;
    cyc(1);
    load = 1'b0;
  endtask

  initial begin
    int nt, nw;
    cyc(2);
    rst = 1'b0;
    chk("rst_count", 32'(cnt[0]), 32'h0000);
    chk("rst_sel", 32'(sel[0]), 32'h1);
    chk("rst_seg", 32'(seg[0]), 32'h3F);
    chk("rst_tick_wrap", {tick[0], wrap[0]}, 32'h0);
    cyc(1);
    en = 1'b1;
    nt = 0;
    nw = 0;
    repeat (40) begin
      cyc(1);
      if (tick[0]) nt++;
      if (wrap[0]) nw++;
    end
    chk("up40_ticks", 32'(nt), 32'd10);
    chk("up40_wraps", 32'(nw), 32'd0);
    chk("up40_count", 32'(cnt[0]), 32'h0010);
    do_load(16'h9999);
    cyc(4);
    chk("wrap_up_count", 32'(cnt[0]), 32'h0000);
    chk("wrap_up_tick_wrap", {tick[0], wrap[0]}, 32'h3);
    dir = 1'b1;
    cyc(4);
    chk("wrap_dn_count", 32'(cnt[0]), 32'h9999);
    chk("wrap_dn_wrap", 32'(wrap[0]), 32'h1);
    dir = 1'b0;
    clear = 1'b1;
    do_load(16'h1234);
    clear = 1'b0;
    chk("clear_over_load", 32'(cnt[0]), 32'h0000);
    cyc(3);
    do_load(16'h0567);
    chk("load_on_roll_count", 32'(cnt[0]), 32'h0567);
    chk("load_on_roll_tick", 32'(tick[0]), 32'h0);
    cyc(3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("midcount_rst_count", 32'(cnt[0]), 32'h0000);
    chk("midcount_rst_tick", 32'(tick[0]), 32'h0);
    en = 1'b0;
    do_reset();
    do_load(16'h1234);
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk($sformatf("scan_sel%0d", i), 32'(sel[0]), 32'(x_sel[i]));
      chk($sformatf("scan_seg%0d", i), 32'(seg[0]), 32'(x_seg[i]));
      chk($sformatf("scan_dp%0d", i), 32'(dpo[0]), 32'(x_dp[i]));
    end
    do_reset();
    do_load(16'h0007);
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk($sformatf("blank_seg%0d", i), 32'(seg[1]), 32'(x_blk[i]));
    end
    en = 1'b1;
    do_reset();
    do_load(16'h00FF);
    cyc(4);
    chk("hex_step_count", 32'(cnt[2]), 32'h0100);
    chk("bcd_clamp_step_count", 32'(cnt[0]), 32'h0100);
    cyc(4);
    chk("hex_digit0_seg", 32'(seg[2]), 32'h3F);
    chk("hex_digit0_sel", 32'(sel[2]), 32'h1);
    en = 1'b0;
    do_load(16'h000C);
    chk("bcd_clamp_load", 32'(cnt[0]), 32'h0009);
    chk("hex_no_clamp_load", 32'(cnt[2]), 32'h000C);
    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
